// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for the AXI4-lite initiator: response codes and FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WREQ  = 3'd1,
    ST_WRESP = 3'd2,
    ST_RREQ  = 3'd3,
    ST_RDATA = 3'd4,
    ST_RSP   = 3'd5
  } state_e;

  // States in which a bus transaction is waiting on the slave.
  function automatic logic is_bus_wait(input state_e s);
    return (s == ST_WREQ) || (s == ST_WRESP) || (s == ST_RREQ) || (s == ST_RDATA);
  endfunction

endpackage

// File: rtl/axi4_lite_master.sv
// AXI4-lite initiator: one command at a time from a valid/ready command port onto AW/W/B or AR/R.
// Optional sticky watchdog flag timeout_err is built only when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module axi4_lite_master
  import axi4_lite_pkg::*;
#(
  parameter int data_width     = 32,
  parameter int addr_width     = 5,
  parameter int timeout_cycles = 256
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  // Every valid/ready pair: transfer happens on a rising edge with valid & ready both high;
  // valid never waits for ready, and valid plus its payload stay stable until that transfer.
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [addr_width-1:0]     cmd_addr,
  input  logic [data_width-1:0]     cmd_wdata,
  input  logic [data_width/8-1:0]   cmd_wstrb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [data_width-1:0]     rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [addr_width-1:0]     AWADDR,
  output logic [2:0]                AWPROT,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [data_width-1:0]     WDATA,
  output logic [data_width/8-1:0]   WSTRB,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [addr_width-1:0]     ARADDR,
  output logic [2:0]                ARPROT,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [data_width-1:0]     RDATA,
  input  logic [1:0]                RRESP,
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  output logic                      timeout_err,
`endif
  output state_e                    state_dbg
);

  localparam int SW = data_width / 8;

  if (((data_width % 8) != 0) || (timeout_cycles < 1)) begin : g_cfg_check
    $error("axi4_lite_master: data_width must be a multiple of 8 and timeout_cycles >= 1");
  end

  state_e                state;
  state_e                state_nxt;
  logic                  aw_pend;
  logic                  w_pend;
  logic [addr_width-1:0] awaddr_q;
  logic [addr_width-1:0] araddr_q;
  logic [data_width-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;
  logic [data_width-1:0] rdata_q;
  logic [1:0]            resp_q;
  logic                  cmd_fire;

  assign cmd_fire = (state == ST_IDLE) && cmd_valid;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // WREQ leaves only once both AW and W have transferred, whichever order they complete in.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_nxt = cmd_write ? ST_WREQ : ST_RREQ;
      ST_WREQ:  if ((!aw_pend || AWREADY) && (!w_pend || WREADY)) state_nxt = ST_WRESP;
      ST_WRESP: if (BVALID) state_nxt = ST_RSP;
      ST_RREQ:  if (ARREADY) state_nxt = ST_RDATA;
      ST_RDATA: if (RVALID) state_nxt = ST_RSP;
      ST_RSP:   if (rsp_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    AWVALID   = aw_pend;
    WVALID    = w_pend;
    BREADY    = (state == ST_WRESP);
    ARVALID   = (state == ST_RREQ);
    RREADY    = (state == ST_RDATA);
    rsp_valid = (state == ST_RSP);
    state_dbg = state;
  end

  // Per-channel pending flags let AW and W complete independently; a flag never re-arms mid-write.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_pend  <= 1'b0;
      w_pend   <= 1'b0;
      awaddr_q <= '0;
      araddr_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      resp_q   <= RESP_OKAY;
    end else begin
      if (cmd_fire) begin
        if (cmd_write) begin
          awaddr_q <= cmd_addr;
          wdata_q  <= cmd_wdata;
          wstrb_q  <= cmd_wstrb;
          aw_pend  <= 1'b1;
          w_pend   <= 1'b1;
        end else begin
          araddr_q <= cmd_addr;
        end
      end
      if (aw_pend && AWREADY) aw_pend <= 1'b0;
      if (w_pend && WREADY) w_pend <= 1'b0;
      if ((state == ST_WRESP) && BVALID) begin
        rdata_q <= '0;
        resp_q  <= BRESP;
      end
      if ((state == ST_RDATA) && RVALID) begin
        rdata_q <= RDATA;
        resp_q  <= RRESP;
      end
    end
  end

  assign AWADDR    = awaddr_q;
  assign WDATA     = wdata_q;
  assign WSTRB     = wstrb_q;
  assign ARADDR    = araddr_q;
  assign AWPROT    = 3'b000;
  assign ARPROT    = 3'b000;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(timeout_cycles + 1);
  localparam logic [TW-1:0] TO_LIMIT = TW'(timeout_cycles);

  logic [TW-1:0] wd_cnt;

  // Counter saturates at the limit; the flag only alerts, the transaction keeps waiting.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (cmd_fire) begin
      wd_cnt <= '0;
    end else if (is_bus_wait(state) && (wd_cnt != TO_LIMIT)) begin
      wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == TO_LIMIT - 1'b1) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_master.sv
// Bench for axi4_lite_master: register-file slave with programmable channel delays, reference model,
// expected-response queue. Timeout checks are built when AXI4_LITE_MASTER_TIMEOUT_EN is defined.
module tb_axi4_lite_master;
  import axi4_lite_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int SW = DW / 8;
  localparam int TO = 256;

  logic          ACLK = 1'b0;
  logic          ARESETn;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic          ARVALID, ARREADY, RVALID, RREADY;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [2:0]    AWPROT, ARPROT;
  logic [DW-1:0] WDATA, RDATA;
  logic [SW-1:0] WSTRB;
  logic [1:0]    BRESP, RRESP;
  state_e        state_dbg;
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 ACLK = ~ACLK;

  axi4_lite_master #(.data_width(DW), .addr_width(AW), .timeout_cycles(TO)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    .timeout_err(timeout_err),
`endif
    .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [DW-1:0]   ref_mem[8];
  logic [DW+1:0]   exp_q[$];

  function automatic logic [DW+1:0] model_txn(input bit wr, input logic [AW-1:0] addr,
                                               input logic [DW-1:0] data, input logic [SW-1:0] strb,
                                               input logic [1:0] resp);
    logic [DW-1:0] mask;
    int idx;
    idx = int'(addr) / 4;
    mask = '0;
    for (int b = 0; b < SW; b++) if (strb[b]) mask = mask | (DW'(32'hFF) << (8 * b));
    if (wr) begin
      if (resp < 2'd2) ref_mem[idx] = (ref_mem[idx] & ~mask) | (data & mask);
      return {resp, {DW{1'b0}}};
    end
    return {resp, ref_mem[idx]};
  endfunction

  // ---------------- slave (register file, programmable delays) ----------------
  int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
  bit            w_after_aw;
  logic [1:0]    inj_resp;
  logic [DW-1:0] slv_mem[8];

  int            aw_cnt, w_cnt, b_cnt, r_cnt;
  bit            aw_got, w_got, ar_got, aw_seen, w_seen, ar_seen, b_sched;
  bit            aw_fire_p, w_fire_p, b_fire_p, ar_fire_p, r_fire_p;
  logic [AW-1:0] cap_awaddr, cap_araddr, aw_hold, ar_hold;
  logic [DW-1:0] cap_wdata, w_hold;
  logic [SW-1:0] cap_wstrb;
  int            n_aw, n_w, n_b, n_ar, n_r;
  int            viol = 0;

  task automatic slave_reset();
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
    ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    aw_got = 0; w_got = 0; ar_got = 0; aw_seen = 0; w_seen = 0; ar_seen = 0; b_sched = 0;
    aw_fire_p = 0; w_fire_p = 0; b_fire_p = 0; ar_fire_p = 0; r_fire_p = 0;
    aw_cnt = aw_dly; w_cnt = w_dly; b_cnt = 0; r_cnt = 0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) slv_mem[i] = '0;
    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0; w_after_aw = 0; inj_resp = 2'b00;
    slave_reset();
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        slave_reset();
        continue;
      end
      // transfers committed at the rising edge just passed
      if (aw_fire_p) begin n_aw++; aw_got = 1; end
      if (w_fire_p) begin n_w++; w_got = 1; end
      if (ar_fire_p) begin n_ar++; ar_got = 1; r_cnt = r_dly; end
      if (b_fire_p) begin
        n_b++; BVALID = 0; aw_got = 0; w_got = 0; aw_seen = 0; w_seen = 0; b_sched = 0;
      end
      if (r_fire_p) begin n_r++; RVALID = 0; ar_got = 0; ar_seen = 0; end
      AWREADY = 0; WREADY = 0; ARREADY = 0;
      // VALID must stay high with stable payload until its transfer, then stay low
      if (aw_got && AWVALID) viol++;
      if (w_got && WVALID) viol++;
      if (ar_got && ARVALID) viol++;
      if (aw_seen && !aw_got && (!AWVALID || AWADDR !== aw_hold)) viol++;
      if (w_seen && !w_got && (!WVALID || WDATA !== w_hold)) viol++;
      if (ar_seen && !ar_got && (!ARVALID || ARADDR !== ar_hold)) viol++;
      if (AWVALID && !aw_got) begin
        if (!aw_seen) begin aw_seen = 1; aw_hold = AWADDR; aw_cnt = aw_dly; end
        if (aw_cnt == 0) AWREADY = 1; else aw_cnt--;
      end
      if (WVALID && !w_got) begin
        if (!w_seen) begin w_seen = 1; w_hold = WDATA; w_cnt = w_dly; end
        if (!w_after_aw || aw_got) begin
          if (w_cnt == 0) WREADY = 1; else w_cnt--;
        end
      end
      if (ARVALID && !ar_got) begin
        if (!ar_seen) begin ar_seen = 1; ar_hold = ARADDR; aw_cnt = ar_dly; end
        if (aw_cnt == 0) ARREADY = 1; else aw_cnt--;
      end
      if (aw_got && w_got && !b_sched) begin
        b_sched = 1; b_cnt = b_dly;
        if (inj_resp < 2'd2)
          for (int b = 0; b < SW; b++)
            if (cap_wstrb[b]) slv_mem[cap_awaddr[4:2]][8*b +: 8] = cap_wdata[8*b +: 8];
      end
      if (b_sched && !BVALID) begin
        if (b_cnt == 0) begin BVALID = 1; BRESP = inj_resp; end else b_cnt--;
      end
      if (ar_got && !RVALID) begin
        if (r_cnt == 0) begin
          RVALID = 1; RDATA = slv_mem[cap_araddr[4:2]]; RRESP = inj_resp;
        end else r_cnt--;
      end
      aw_fire_p = AWVALID && AWREADY;
      w_fire_p  = WVALID && WREADY;
      ar_fire_p = ARVALID && ARREADY;
      b_fire_p  = BVALID && BREADY;
      r_fire_p  = RVALID && RREADY;
      if (aw_fire_p) cap_awaddr = AWADDR;
      if (w_fire_p) begin cap_wdata = WDATA; cap_wstrb = WSTRB; end
      if (ar_fire_p) cap_araddr = ARADDR;
    end
  end

  // ---------------- driver ----------------
  task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input logic [SW-1:0] strb, input int hold, input bit chk_lat);
    int k;
    int lat;
    logic [DW+1:0] snap;
    logic [DW+1:0] exp;
    exp_q.push_back(model_txn(wr, addr, data, strb, inj_resp));
    n_aw = 0; n_w = 0; n_b = 0; n_ar = 0; n_r = 0;
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge ACLK); k++; end
    if (!cmd_ready) begin
      check_eq("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
      cmd_valid = 0; void'(exp_q.pop_front()); return;
    end
    @(negedge ACLK);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 1000) begin @(negedge ACLK); lat++; end
    if (!rsp_valid) begin
      check_eq("rsp_timeout", 64'(rsp_valid), 64'd1);
      void'(exp_q.pop_front()); return;
    end
    if (chk_lat) check_eq(wr ? "wr_latency" : "rd_latency", 64'(lat), 64'd3);
    snap = {rsp_resp, rsp_rdata};
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check_eq("rsp_hold", {rsp_valid, cmd_ready, rsp_resp, rsp_rdata}, {2'b10, snap});
    end
    exp = exp_q.pop_front();
    check_eq(wr ? "wr_rsp" : "rd_rsp", 64'({rsp_resp, rsp_rdata}), 64'(exp));
    if (wr) check_eq("aw_w_payload", {cap_awaddr, cap_wdata, cap_wstrb}, {addr, data, strb});
    else    check_eq("ar_payload", 64'(cap_araddr), 64'(addr));
    check_eq("hs_counts", {8'(n_aw), 8'(n_w), 8'(n_b), 8'(n_ar), 8'(n_r)},
             wr ? 40'h01_01_01_00_00 : 40'h00_00_00_01_01);
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
    check_eq("rsp_done_idle", {rsp_valid, cmd_ready}, 2'b01);
  endtask

  task automatic set_delays(input int a, input int w, input int b, input int ar, input int r);
    aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int k;
    int seen;
    for (int i = 0; i < 8; i++) ref_mem[i] = '0;
    ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    check_eq("reset_ctrl", {cmd_ready, rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY}, 7'b1000000);
    check_eq("reset_data", {rsp_resp, rsp_rdata, AWADDR, ARADDR, WSTRB}, '0);
    check_eq("reset_wdata_prot", {WDATA, AWPROT, ARPROT}, '0);
`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    check_eq("reset_timeout_err", 64'(timeout_err), 64'd0);
`endif

    // zero-wait write then read back, with latency
    set_delays(0, 0, 0, 0, 0);
    do_txn(1, 5'h10, 32'hDEADBEEF, 4'hF, 0, 1);
    do_txn(0, 5'h10, '0, '0, 0, 1);

    // delayed AW/W handshakes, independent completion
    set_delays(3, 5, 1, 0, 0);
    do_txn(1, 5'h04, 32'h1234_5678, 4'hF, 0, 0);
    set_delays(5, 1, 0, 0, 0);
    do_txn(1, 5'h08, 32'hA5A5_A5A5, 4'h5, 0, 0);
    // slave withholds WREADY until AW taken
    w_after_aw = 1;
    set_delays(2, 0, 2, 0, 0);
    do_txn(1, 5'h0C, 32'hCAFE_F00D, 4'hA, 0, 0);
    w_after_aw = 0;

    // response held 4 cycles
    set_delays(0, 0, 0, 2, 3);
    do_txn(0, 5'h04, '0, '0, 4, 0);

    // error response passthrough
    inj_resp = 2'b10;
    do_txn(0, 5'h08, '0, '0, 1, 0);
    do_txn(1, 5'h08, 32'hFFFF_FFFF, 4'hF, 0, 0);
    inj_resp = 2'b00;
    do_txn(0, 5'h08, '0, '0, 0, 0);

    // reset while RREADY is high
    set_delays(0, 0, 0, 0, 20);
    @(negedge ACLK);
    cmd_valid = 1; cmd_write = 0; cmd_addr = 5'h10;
    @(negedge ACLK);
    cmd_valid = 0;
    k = 0;
    while (!RREADY && k < 20) begin @(negedge ACLK); k++; end
    check_eq("rready_before_reset", 64'(RREADY), 64'd1);
    #2 ARESETn = 0;
    #1;
    check_eq("async_reset_outs",
             {rsp_valid, AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_resp, rsp_rdata, ARADDR}, '0);
    repeat (2) @(negedge ACLK);
    #2 ARESETn = 1;
    @(negedge ACLK);
    check_eq("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);
    seen = 0;
    repeat (25) begin @(negedge ACLK); if (rsp_valid) seen++; end
    check_eq("no_rsp_after_reset", 64'(seen), 64'd0);
    set_delays(0, 0, 0, 0, 0);
    do_txn(0, 5'h10, '0, '0, 0, 1);

    // randomized traffic
    for (int t = 0; t < 60; t++) begin
      set_delays($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3),
                 $urandom_range(0, 4), $urandom_range(0, 3));
      w_after_aw = 1'($urandom_range(0, 1));
      inj_resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      do_txn(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
             4'($urandom_range(0, 15)), $urandom_range(0, 3), 0);
    end
    inj_resp = 2'b00; w_after_aw = 0;

`ifdef AXI4_LITE_MASTER_TIMEOUT_EN
    set_delays(0, 0, 300, 0, 0);
    fork
      do_txn(1, 5'h18, 32'h0BAD_F00D, 4'hF, 0, 0);
      begin
        repeat (200) @(negedge ACLK);
        check_eq("timeout_not_yet", 64'(timeout_err), 64'd0);
        repeat (80) @(negedge ACLK);
        check_eq("timeout_set", 64'(timeout_err), 64'd1);
      end
    join
    check_eq("timeout_sticky", 64'(timeout_err), 64'd1);
    set_delays(0, 0, 0, 0, 0);
    do_txn(0, 5'h18, '0, '0, 0, 1);
`endif

    check_eq("protocol_violations", 64'(viol), 64'd0);
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_watchdog: got=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

endmodule
